// File: rtl/inst_fetch_if.sv
// Instruction memory read bus: request/acknowledge handshake with address and returned word.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: reads the word at the PC over a req/ack bus and loads the IF/ID register,
// holding the PC via stall_o until each instruction has been handed to decode.
module inst_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              id_stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  inst_fetch_if.master      mem,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              fetch_err_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              drop_q;
  logic [7:0]        tcnt;
  logic [ADDR_W-1:0] hold_pc;
  logic [DATA_W-1:0] hold_inst;

  logic              deliver_now;
  logic [ADDR_W-1:0] src_pc;
  logic [DATA_W-1:0] src_inst;

  // Delivery source is the live bus word in WAIT, the hold buffer in HOLD; flush always vetoes.
  always_comb begin
    deliver_now = 1'b0;
    src_pc      = hold_pc;
    src_inst    = hold_inst;
    case (state)
      S_WAIT: begin
        deliver_now = mem.mem_ack_i & ~drop_q & ~flush_i & ~id_stall_i;
        src_pc      = addr_q;
        src_inst    = mem.mem_rdata_i;
      end
      S_HOLD:  deliver_now = ~flush_i & ~id_stall_i;
      default: deliver_now = 1'b0;
    endcase
  end

  assign stall_o        = ce_i & ~deliver_now;
  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      drop_q      <= 1'b0;
      tcnt        <= '0;
      hold_pc     <= '0;
      hold_inst   <= '0;
      if_pc_o     <= '0;
      if_inst_o   <= '0;
      if_valid_o  <= 1'b0;
      fetch_err_o <= 1'b0;
    end else begin
      if (deliver_now) begin
        if_pc_o   <= src_pc;
        if_inst_o <= src_inst;
      end

      if (flush_i)
        if_valid_o <= 1'b0;
      else if (deliver_now)
        if_valid_o <= 1'b1;
      else if (!id_stall_i)
        if_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ce_i && !flush_i) begin
            addr_q <= pc_i;
            drop_q <= 1'b0;
            tcnt   <= '0;
            req_q  <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack_i) begin
            req_q <= 1'b0;
            if (drop_q || flush_i || !id_stall_i) begin
              state <= S_IDLE;
            end else begin
              hold_pc   <= addr_q;
              hold_inst <= mem.mem_rdata_i;
              state     <= S_HOLD;
            end
          end else begin
            if (flush_i) drop_q <= 1'b1;
            if (tcnt != TMO) tcnt <= tcnt + 8'd1;
            // Flag on the same edge the count reaches TIMEOUT.
            if (tcnt >= TMO - 8'd1) fetch_err_o <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush_i || !id_stall_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
